id_ex_operand_stage: RTL and testbench

//  Pipeline register between decode/register-file read and the wrapped ALU (execute) stage.

---
 rtl/id_ex_operand_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// Pipeline register between decode / register-file read and the ALU stage.
// Captures one decoded instruction per valid/ready handshake, resolves RAW
// hazards by forwarding from the EX/MEM and MEM/WB result buses, and holds
// the instruction (out_valid low) while a source operand waits on a load
// that has not returned yet. Forwarding is re-evaluated every cycle the
// slot stays occupied, so a load is picked up from MEM/WB one cycle after
// it leaves EX/MEM.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kills held instruction and incoming transfer
//   in_valid/in_ready   decode-side handshake
//   in_rs*_idx/_val     source indices and register-file read values
//   in_imm, in_use_imm  immediate and operand-2 select
//   in_op/mod/op2_neg   ALU control
//   in_rd, in_rd_we     destination, carried downstream
//   exmem_*             EX/MEM forwarding bus (data_ok=0: load pending)
//   memwb_*             MEM/WB forwarding bus (always final)
//   out_valid/out_ready ALU-side handshake
//   out_*               registered operands / control to the ALU
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RIDX_W-1:0] in_rs1_idx,
    input  logic [RIDX_W-1:0] in_rs2_idx,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [2:0]        in_op,
    input  logic              in_mod,
    input  logic              in_op2_neg,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic              exmem_we,
    input  logic [RIDX_W-1:0] exmem_rd,
    input  logic              exmem_data_ok,
    input  logic [XLEN-1:0]   exmem_val,
    input  logic              memwb_we,
    input  logic [RIDX_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_use_imm,
    output logic [2:0]        out_op,
    output logic              out_mod,
    output logic              out_op2_neg,
    output logic [RIDX_W-1:0] out_rd,
    output logic              out_rd_we
);

    logic              occ_p0;
    logic              rdy1_p0;
    logic              rdy2_p0;
    logic [RIDX_W-1:0] rs1_idx_p0;
    logic [RIDX_W-1:0] rs2_idx_p0;

    logic              capture;
    logic              consume;
    logic [XLEN:0]     res1_cap;
    logic [XLEN:0]     res2_cap;
    logic [XLEN:0]     res1_hold;
    logic [XLEN:0]     res2_hold;

    // Returns {rdy, value}. EX/MEM wins over MEM/WB (youngest producer).
    // A pending load leaves the value untouched and drops rdy.
    function automatic logic [XLEN:0] resolve(
        input logic [RIDX_W-1:0] idx,
        input logic [XLEN-1:0]   cur_val,
        input logic              cur_rdy,
        input logic              ex_we,
        input logic [RIDX_W-1:0] ex_rd,
        input logic              ex_ok,
        input logic [XLEN-1:0]   ex_val,
        input logic              wb_we,
        input logic [RIDX_W-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_val
    );
        logic [XLEN:0] r;
        r = {cur_rdy, cur_val};
        if (idx == '0)
            r = {1'b1, {XLEN{1'b0}}};
        else if (ex_we && (ex_rd == idx))
            r = ex_ok ? {1'b1, ex_val} : {1'b0, cur_val};
        else if (wb_we && (wb_rd == idx))
            r = {1'b1, wb_val};
        return r;
    endfunction

    assign out_valid = occ_p0 & rdy1_p0 & rdy2_p0;
    assign in_ready  = !flush & (!occ_p0 | (out_valid & out_ready));
    assign capture   = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        res1_cap  = resolve(in_rs1_idx, in_rs1_val, 1'b1, exmem_we, exmem_rd,
                            exmem_data_ok, exmem_val, memwb_we, memwb_rd, memwb_val);
        res2_cap  = resolve(in_rs2_idx, in_rs2_val, 1'b1, exmem_we, exmem_rd,
                            exmem_data_ok, exmem_val, memwb_we, memwb_rd, memwb_val);
        res1_hold = resolve(rs1_idx_p0, out_rs1_val, rdy1_p0, exmem_we, exmem_rd,
                            exmem_data_ok, exmem_val, memwb_we, memwb_rd, memwb_val);
        res2_hold = resolve(rs2_idx_p0, out_rs2_val, rdy2_p0, exmem_we, exmem_rd,
                            exmem_data_ok, exmem_val, memwb_we, memwb_rd, memwb_val);
    end

    // ---- ID/EX register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_p0      <= 1'b0;
            rdy1_p0     <= 1'b0;
            rdy2_p0     <= 1'b0;
            rs1_idx_p0  <= '0;
            rs2_idx_p0  <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_use_imm <= 1'b0;
            out_op      <= '0;
            out_mod     <= 1'b0;
            out_op2_neg <= 1'b0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
        end else if (flush) begin
            occ_p0  <= 1'b0;
            rdy1_p0 <= 1'b0;
            rdy2_p0 <= 1'b0;
        end else if (capture) begin
            occ_p0      <= 1'b1;
            rdy1_p0     <= res1_cap[XLEN];
            // The immediate replaces rs2, so a pending rs2 load never stalls.
            rdy2_p0     <= res2_cap[XLEN] | in_use_imm;
            rs1_idx_p0  <= in_rs1_idx;
            rs2_idx_p0  <= in_rs2_idx;
            out_rs1_val <= res1_cap[XLEN-1:0];
            out_rs2_val <= res2_cap[XLEN-1:0];
            out_imm     <= in_imm;
            out_use_imm <= in_use_imm;
            out_op      <= in_op;
            out_mod     <= in_mod;
            out_op2_neg <= in_op2_neg;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
        end else if (consume) begin
            // Bubble: operand fields keep their last value.
            occ_p0 <= 1'b0;
        end else if (occ_p0) begin
            // Held (stalled or backpressured): keep re-forwarding.
            rdy1_p0     <= res1_hold[XLEN];
            rdy2_p0     <= res2_hold[XLEN] | out_use_imm;
            out_rs1_val <= res1_hold[XLEN-1:0];
            out_rs2_val <= res2_hold[XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Directed bench for id_ex_operand_stage: reset, plain capture, EX/MEM and
// MEM/WB forwarding priority, load-use stall, x0 and immediate handling,
// backpressure with flush, and asynchronous reset during a hold.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [RIDX_W-1:0] in_rs1_idx, in_rs2_idx;
    logic [XLEN-1:0]   in_rs1_val, in_rs2_val, in_imm;
    logic              in_use_imm;
    logic [2:0]        in_op;
    logic              in_mod, in_op2_neg;
    logic [RIDX_W-1:0] in_rd;
    logic              in_rd_we;
    logic              exmem_we;
    logic [RIDX_W-1:0] exmem_rd;
    logic              exmem_data_ok;
    logic [XLEN-1:0]   exmem_val;
    logic              memwb_we;
    logic [RIDX_W-1:0] memwb_rd;
    logic [XLEN-1:0]   memwb_val;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rs1_val, out_rs2_val, out_imm;
    logic              out_use_imm;
    logic [2:0]        out_op;
    logic              out_mod, out_op2_neg;
    logic [RIDX_W-1:0] out_rd;
    logic              out_rd_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op),
        .in_mod(in_mod), .in_op2_neg(in_op2_neg),
        .in_rd(in_rd), .in_rd_we(in_rd_we),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd),
        .exmem_data_ok(exmem_data_ok), .exmem_val(exmem_val),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_use_imm(out_use_imm), .out_op(out_op),
        .out_mod(out_mod), .out_op2_neg(out_op2_neg),
        .out_rd(out_rd), .out_rd_we(out_rd_we)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        exmem_we = 0; exmem_rd = '0; exmem_data_ok = 1; exmem_val = '0;
        memwb_we = 0; memwb_rd = '0; memwb_val = '0;
    endtask

    task automatic drive_instr(input logic [4:0] r1, input logic [31:0] v1,
                               input logic [4:0] r2, input logic [31:0] v2,
                               input logic [2:0] op, input logic [4:0] rd);
        in_valid = 1; in_rs1_idx = r1; in_rs1_val = v1;
        in_rs2_idx = r2; in_rs2_val = v2; in_op = op; in_rd = rd; in_rd_we = 1;
    endtask

    task automatic drain();
        in_valid = 0; flush = 0; out_ready = 1; in_use_imm = 0;
        clear_fwd();
        step(); step();
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_rs1_val !== 32'h0) begin errors++; $display("FAIL reset_rs1: got %h want 0", out_rs1_val); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", out_rd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_no_hazard();
        drive_instr(5'd1, 32'd5, 5'd2, 32'd7, 3'd0, 5'd3);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nohaz_in_ready_pre: got %0b want 1", in_ready); end
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nohaz_valid: got %0b want 1", out_valid); end
        checks++; if (out_rs1_val !== 32'd5) begin errors++; $display("FAIL nohaz_rs1: got %h want 5", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'd7) begin errors++; $display("FAIL nohaz_rs2: got %h want 7", out_rs2_val); end
        checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL nohaz_rd: got %0d want 3", out_rd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nohaz_in_ready: got %0b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nohaz_bubble: got %0b want 0", out_valid); end
        checks++; if (out_rs1_val !== 32'd5) begin errors++; $display("FAIL nohaz_bubble_hold: got %h want 5", out_rs1_val); end
    endtask

    task automatic test_exmem_fwd();
        drive_instr(5'd3, 32'h11, 5'd5, 32'h22, 3'd1, 5'd10);
        exmem_we = 1; exmem_rd = 5'd3; exmem_val = 32'hAA; exmem_data_ok = 1;
        step();
        checks++; if (out_rs1_val !== 32'hAA) begin errors++; $display("FAIL exmem_rs1: got %h want aa", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'h22) begin errors++; $display("FAIL exmem_rs2: got %h want 22", out_rs2_val); end
        // Back-to-back capture with MEM/WB also matching: EX/MEM must win.
        memwb_we = 1; memwb_rd = 5'd3; memwb_val = 32'hBB; in_rd = 5'd11;
        step();
        checks++; if (out_rs1_val !== 32'hAA) begin errors++; $display("FAIL exmem_prio: got %h want aa", out_rs1_val); end
        checks++; if (out_rd !== 5'd11) begin errors++; $display("FAIL b2b_rd: got %0d want 11", out_rd); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b want 1", out_valid); end
        // MEM/WB alone supplies the value when EX/MEM does not match.
        exmem_we = 0; in_rs1_idx = 5'd3; in_rd = 5'd12;
        step();
        in_valid = 0;
        checks++; if (out_rs1_val !== 32'hBB) begin errors++; $display("FAIL memwb_rs1: got %h want bb", out_rs1_val); end
        drain();
    endtask

    task automatic test_load_use();
        drive_instr(5'd0, 32'h0, 5'd4, 32'h44, 3'd2, 5'd13);
        exmem_we = 1; exmem_rd = 5'd4; exmem_data_ok = 0; exmem_val = 32'h99;
        step();
        in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_stall_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_in_ready: got %0b want 0", in_ready); end
        exmem_we = 0; exmem_data_ok = 1;
        memwb_we = 1; memwb_rd = 5'd4; memwb_val = 32'h55;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_resume_valid: got %0b want 1", out_valid); end
        checks++; if (out_rs2_val !== 32'h55) begin errors++; $display("FAIL lu_rs2: got %h want 55", out_rs2_val); end
        memwb_we = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_consumed: got %0b want 0", out_valid); end
        drain();
    endtask

    task automatic test_x0_imm();
        drive_instr(5'd0, 32'h12, 5'd2, 32'h20, 3'd0, 5'd1);
        exmem_we = 1; exmem_rd = 5'd0; exmem_val = 32'hFF; exmem_data_ok = 1;
        step();
        checks++; if (out_rs1_val !== 32'h0) begin errors++; $display("FAIL x0_rs1: got %h want 0", out_rs1_val); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %0b want 1", out_valid); end
        drive_instr(5'd1, 32'h10, 5'd6, 32'h66, 3'd3, 5'd2);
        in_use_imm = 1; in_imm = 32'h123;
        exmem_we = 1; exmem_rd = 5'd6; exmem_data_ok = 0;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL imm_valid: got %0b want 1", out_valid); end
        checks++; if (out_imm !== 32'h123) begin errors++; $display("FAIL imm_val: got %h want 123", out_imm); end
        checks++; if (out_use_imm !== 1'b1) begin errors++; $display("FAIL imm_use: got %0b want 1", out_use_imm); end
        drain();
    endtask

    task automatic test_backpressure_flush();
        out_ready = 0;
        drive_instr(5'd7, 32'h77, 5'd8, 32'h88, 3'd5, 5'd9);
        in_mod = 1; in_op2_neg = 1;
        step();
        // Keep offering a different instruction; it must not overwrite the slot.
        in_rs1_val = 32'hDEAD; in_op = 3'd2; in_mod = 0; in_op2_neg = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
            checks++; if (out_rs1_val !== 32'h77) begin errors++; $display("FAIL bp_rs1[%0d]: got %h want 77", i, out_rs1_val); end
            checks++; if ({out_op, out_mod, out_op2_neg} !== {3'd5, 1'b1, 1'b1}) begin errors++; $display("FAIL bp_ctrl[%0d]: got %b want 10111", i, {out_op, out_mod, out_op2_neg}); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
            step();
        end
        flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_during: got %0b want 0", in_ready); end
        step();
        flush = 0; in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
        in_mod = 0; in_op2_neg = 0;
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        drive_instr(5'd1, 32'h31, 5'd2, 32'h32, 3'd3, 5'd4);
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %0b want 1", out_valid); end
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %0b want 0", out_valid); end
        checks++; if (out_rs1_val !== 32'h0) begin errors++; $display("FAIL ar_rs1: got %h want 0", out_rs1_val); end
        checks++; if ({out_op, out_rd, out_rd_we} !== 9'd0) begin errors++; $display("FAIL ar_ctrl: got %h want 0", {out_op, out_rd, out_rd_we}); end
        #1 rst_n = 1;
        out_ready = 1;
        drive_instr(5'd1, 32'h41, 5'd2, 32'h42, 3'd1, 5'd5);
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_post_valid: got %0b want 1", out_valid); end
        checks++; if (out_rs1_val !== 32'h41) begin errors++; $display("FAIL ar_post_rs1: got %h want 41", out_rs1_val); end
        drain();
    endtask

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
        in_rs1_idx = '0; in_rs2_idx = '0; in_rs1_val = '0; in_rs2_val = '0;
        in_imm = '0; in_use_imm = 0; in_op = '0; in_mod = 0; in_op2_neg = 0;
        in_rd = '0; in_rd_we = 0;
        clear_fwd();
        #3;
        test_reset();
        step();
        rst_n = 1;
        step();
        test_no_hazard();
        test_exmem_fwd();
        test_load_use();
        test_x0_imm();
        test_backpressure_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
